// File: rtl/seg_pkg.sv
// -----------------------------------------------------------------------------
// seg_pkg
// Shared definitions for the seven-segment display scheduler:
//   - state_e     : scheduler state encoding (IDLE / SHOW)
//   - SEG_DATA_W  : width of the SegmentGenerator Result bus
//   - SRC_IDX_W   : width of a source index (Src_Idx output, up to 8 sources)
//   - clog2()     : ceiling log2 used to size the dwell counter
// -----------------------------------------------------------------------------
package seg_pkg;

  localparam int unsigned SEG_DATA_W = 8;
  localparam int unsigned SRC_IDX_W  = 3;

  typedef enum logic {
    IDLE = 1'b0,
    SHOW = 1'b1
  } state_e;

  // Ceiling log2; returns 0 for values 0 and 1.
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(value)) begin
        r = i + 1;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// -----------------------------------------------------------------------------
// rr_pick
// Combinational round-robin picker. Scans the request vector starting at
// start_i and wrapping modulo NUM_SRC; optionally ignores one index.
// Ports:
//   req_i       in  NUM_SRC    request vector
//   start_i     in  SRC_IDX_W  first index to examine (must be < NUM_SRC)
//   excl_en_i   in  1          enable exclusion of excl_idx_i
//   excl_idx_i  in  SRC_IDX_W  index to exclude from the search
//   found_o     out 1          some eligible request exists
//   idx_o       out SRC_IDX_W  winning index (0 when none found)
// -----------------------------------------------------------------------------
module rr_pick
  import seg_pkg::*;
#(
  parameter int unsigned NUM_SRC = 4
) (
  input  logic [NUM_SRC-1:0]   req_i,
  input  logic [SRC_IDX_W-1:0] start_i,
  input  logic                 excl_en_i,
  input  logic [SRC_IDX_W-1:0] excl_idx_i,
  output logic                 found_o,
  output logic [SRC_IDX_W-1:0] idx_o
);

  logic [NUM_SRC-1:0]   req_ok_c;
  logic [2*NUM_SRC-1:0] dbl_c;
  logic [NUM_SRC-1:0]   rot_c;

  // Mask out the excluded source.
  always_comb begin
    req_ok_c = '0;
    for (int unsigned i = 0; i < NUM_SRC; i++) begin
      req_ok_c[i] = req_i[i] & ~(excl_en_i & (excl_idx_i == SRC_IDX_W'(i)));
    end
  end

  // Rotate so bit 0 corresponds to start_i; the doubled vector handles the wrap.
  always_comb begin
    dbl_c = {req_ok_c, req_ok_c} >> start_i;
    rot_c = dbl_c[NUM_SRC-1:0];
  end

  // First set bit of the rotated vector, mapped back to an absolute index.
  always_comb begin
    int unsigned sum;
    sum     = 0;
    found_o = 1'b0;
    idx_o   = '0;
    for (int unsigned k = 0; k < NUM_SRC; k++) begin
      if (!found_o && rot_c[k]) begin
        found_o = 1'b1;
        sum     = 32'(start_i) + k;
        if (sum >= NUM_SRC) begin
          sum = sum - NUM_SRC;
        end
        idx_o = SRC_IDX_W'(sum);
      end
    end
  end

endmodule

// File: rtl/seg_display_scheduler.sv
// -----------------------------------------------------------------------------
// seg_display_scheduler
// Time-shares a two-digit seven-segment display between NUM_SRC result
// sources in round-robin order, guaranteeing each granted source at least
// DWELL_CYCLES clocks on the display while others are waiting.
// Ports:
//   CLK      in  1                system clock, rising edge
//   Reset    in  1                synchronous active-high reset
//   Req      in  NUM_SRC          per-source level request
//   Data     in  NUM_SRC*DATA_W   packed source values, source i at [i*DATA_W +: DATA_W]
//   Freeze   in  1                pauses the dwell counter (no rotation)
//   Result   out DATA_W           registered value for SegmentGenerator
//   Grant    out NUM_SRC          registered one-hot grant, zero when idle
//   Src_Idx  out 3                registered granted index, zero when idle
//   Valid    out 1                high while a source is granted
// -----------------------------------------------------------------------------
module seg_display_scheduler
  import seg_pkg::*;
#(
  parameter int unsigned NUM_SRC      = 4,
  parameter int unsigned DATA_W       = SEG_DATA_W,
  parameter int unsigned DWELL_CYCLES = 50_000_000
) (
  input  logic                        CLK,
  input  logic                        Reset,
  input  logic [NUM_SRC-1:0]          Req,
  input  logic [NUM_SRC*DATA_W-1:0]   Data,
  input  logic                        Freeze,
  output logic [DATA_W-1:0]           Result,
  output logic [NUM_SRC-1:0]          Grant,
  output logic [SRC_IDX_W-1:0]        Src_Idx,
  output logic                        Valid
);

  localparam int unsigned        DW_W    = clog2(DWELL_CYCLES);
  localparam logic [DW_W-1:0]    DW_LOAD = DW_W'(DWELL_CYCLES - 1);
  localparam logic [SRC_IDX_W-1:0] LAST_RST = SRC_IDX_W'(NUM_SRC - 1);

  state_e                 state_q;
  logic [SRC_IDX_W-1:0]   last_q;
  logic [SRC_IDX_W-1:0]   src_idx_q;
  logic [NUM_SRC-1:0]     grant_q;
  logic                   valid_q;
  logic [DATA_W-1:0]      result_q;
  logic [DW_W-1:0]        dwell_q;

  logic [SRC_IDX_W-1:0]   start_c;
  logic                   excl_en_c;
  logic                   pick_found_c;
  logic [SRC_IDX_W-1:0]   pick_idx_c;
  logic                   cur_req_c;
  logic                   expired_c;
  logic                   take_c;
  logic                   drop_c;
  logic [NUM_SRC-1:0]     win_grant_c;
  logic [DATA_W-1:0]      win_data_c;
  logic [DATA_W-1:0]      cur_data_c;

  // Search begins one past the most recent grant, wrapping at NUM_SRC.
  always_comb begin
    start_c = (last_q >= LAST_RST) ? '0 : last_q + SRC_IDX_W'(1);
  end

  // In SHOW the current source is last_q, so excluding last_q excludes g.
  assign excl_en_c = (state_q == SHOW);

  rr_pick #(
    .NUM_SRC (NUM_SRC)
  ) u_rr_pick (
    .req_i      (Req),
    .start_i    (start_c),
    .excl_en_i  (excl_en_c),
    .excl_idx_i (last_q),
    .found_o    (pick_found_c),
    .idx_o      (pick_idx_c)
  );

  // Current source still requesting, and dwell expiry.
  assign cur_req_c = |(Req & grant_q);
  assign expired_c = (dwell_q == '0);

  // Grant decision: a new winner is taken from IDLE, on a drop of the current
  // source, or on expiry with Freeze low. A drop beats a concurrent rotation
  // simply because both land on the same winner.
  always_comb begin
    take_c = 1'b0;
    drop_c = 1'b0;
    if (state_q == IDLE) begin
      take_c = pick_found_c;
    end else if (!cur_req_c) begin
      take_c = pick_found_c;
      drop_c = !pick_found_c;
    end else begin
      take_c = pick_found_c && expired_c && !Freeze;
    end
  end

  // One-hot grant and data for the winner; data of the current source.
  always_comb begin
    win_grant_c = '0;
    win_data_c  = '0;
    cur_data_c  = '0;
    for (int unsigned i = 0; i < NUM_SRC; i++) begin
      if (pick_idx_c == SRC_IDX_W'(i)) begin
        win_grant_c[i] = 1'b1;
        win_data_c     = Data[i*DATA_W +: DATA_W];
      end
      if (src_idx_q == SRC_IDX_W'(i)) begin
        cur_data_c = Data[i*DATA_W +: DATA_W];
      end
    end
  end

  // Scheduler FSM, dwell counter and output registers.
  always_ff @(posedge CLK) begin
    if (Reset) begin
      state_q   <= IDLE;
      last_q    <= LAST_RST;
      src_idx_q <= '0;
      grant_q   <= '0;
      valid_q   <= 1'b0;
      result_q  <= '0;
      dwell_q   <= '0;
    end else if (take_c) begin
      state_q   <= SHOW;
      last_q    <= pick_idx_c;
      src_idx_q <= pick_idx_c;
      grant_q   <= win_grant_c;
      valid_q   <= 1'b1;
      result_q  <= win_data_c;
      dwell_q   <= DW_LOAD;
    end else if (drop_c) begin
      // Result is left untouched so the digits do not blank.
      state_q   <= IDLE;
      src_idx_q <= '0;
      grant_q   <= '0;
      valid_q   <= 1'b0;
      dwell_q   <= '0;
    end else if (state_q == SHOW) begin
      result_q <= cur_data_c;
      if (!expired_c && !Freeze) begin
        dwell_q <= dwell_q - DW_W'(1);
      end
    end
  end

  assign Result  = result_q;
  assign Grant   = grant_q;
  assign Src_Idx = src_idx_q;
  assign Valid   = valid_q;

endmodule

// File: tb/tb_seg_display_scheduler.sv
// -----------------------------------------------------------------------------
// tb_seg_display_scheduler
// Directed bench for seg_display_scheduler with NUM_SRC=4, DWELL_CYCLES=4.
// A behavioural reference pushes the expected outputs for every clock into a
// scoreboard queue; the entry is popped and compared after the edge.
// -----------------------------------------------------------------------------
module tb_seg_display_scheduler;

  localparam int NS    = 4;
  localparam int DW    = 8;
  localparam int DWELL = 4;

  typedef struct {
    logic [3:0] g;
    logic [2:0] i;
    logic       v;
    logic [7:0] r;
  } exp_t;

  logic        CLK;
  logic        Reset;
  logic [3:0]  Req;
  logic [31:0] Data;
  logic        Freeze;
  logic [7:0]  Result;
  logic [3:0]  Grant;
  logic [2:0]  Src_Idx;
  logic        Valid;

  int compared;
  int mism;

  // Reference state: granted source (-1 idle), last grant, shown cycles.
  int         m_g;
  int         m_last;
  int         m_age;
  logic [7:0] m_res;

  exp_t sb[$];

  logic [3:0] rot_g [4] = '{4'b0001, 4'b0010, 4'b1000, 4'b0001};
  logic [7:0] rot_r [4] = '{8'h11, 8'h22, 8'h44, 8'h11};

  seg_display_scheduler #(
    .NUM_SRC      (NS),
    .DATA_W       (DW),
    .DWELL_CYCLES (DWELL)
  ) dut (
    .CLK     (CLK),
    .Reset   (Reset),
    .Req     (Req),
    .Data    (Data),
    .Freeze  (Freeze),
    .Result  (Result),
    .Grant   (Grant),
    .Src_Idx (Src_Idx),
    .Valid   (Valid)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  function automatic int rr(input logic [3:0] req, input int start, input int excl);
    for (int k = 0; k < NS; k++) begin
      int c;
      c = (start + k) % NS;
      if (c != excl && req[c]) return c;
    end
    return -1;
  endfunction

  task automatic grant_to(input int w);
    m_g    = w;
    m_last = w;
    m_age  = 0;
    m_res  = Data[w*8 +: 8];
  endtask

  // Advance the reference by one clock using the inputs now applied.
  task automatic model_step();
    int w;
    if (Reset) begin
      m_g = -1; m_last = NS - 1; m_age = 0; m_res = 8'h00;
    end else if (m_g < 0) begin
      w = rr(Req, (m_last + 1) % NS, -1);
      if (w >= 0) grant_to(w);
    end else if (!Req[m_g]) begin
      w = rr(Req, (m_g + 1) % NS, m_g);
      if (w >= 0) grant_to(w);
      else m_g = -1;
    end else begin
      w = rr(Req, (m_g + 1) % NS, m_g);
      if (m_age >= DWELL - 1 && !Freeze && w >= 0) begin
        grant_to(w);
      end else begin
        m_res = Data[m_g*8 +: 8];
        if (!Freeze) m_age++;
      end
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mism++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Push expected, clock once, pop and compare all outputs.
  task automatic tick();
    exp_t e;
    model_step();
    e.g = (m_g < 0) ? 4'b0000 : (4'b0001 << m_g);
    e.i = (m_g < 0) ? 3'd0 : 3'(m_g);
    e.v = (m_g >= 0);
    e.r = m_res;
    sb.push_back(e);
    @(posedge CLK);
    #1;
    e = sb.pop_front();
    check("sb_grant",  32'(Grant),   32'(e.g));
    check("sb_idx",    32'(Src_Idx), 32'(e.i));
    check("sb_valid",  32'(Valid),   32'(e.v));
    check("sb_result", 32'(Result),  32'(e.r));
  endtask

  initial begin
    int len;
    compared = 0;
    mism     = 0;
    m_g = -1; m_last = NS - 1; m_age = 0; m_res = 8'h00;
    Reset  = 1'b1;
    Req    = 4'b1111;
    Data   = 32'h4433_2211;
    Freeze = 1'b0;

    // Reset held with all requests high.
    repeat (3) begin
      tick();
      check("rst_grant", 32'(Grant), 32'h0);
      check("rst_valid", 32'(Valid), 32'h0);
    end
    Reset = 1'b0;
    tick();
    check("rel_grant", 32'(Grant),   32'h1);
    check("rel_idx",   32'(Src_Idx), 32'h0);

    // Rotation over sources 0, 1, 3, 0 with 4-cycle dwell.
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    Req   = 4'b1011;
    for (int p = 0; p < 4; p++) begin
      for (int c = 0; c < 4; c++) begin
        tick();
        check("rot_grant",  32'(Grant),  32'(rot_g[p]));
        check("rot_result", 32'(Result), 32'(rot_r[p]));
      end
    end

    // Early drop: source 1 drops in its 2nd cycle, source 2 takes over.
    Req = 4'b0110;
    tick();
    check("drop_g1", 32'(Grant), 32'b0010);
    tick();
    Req = 4'b0100;
    tick();
    check("drop_g2",   32'(Grant), 32'b0100);
    check("drop_v2",   32'(Valid), 32'h1);
    Req = 4'b0000;
    tick();
    check("idle_valid",  32'(Valid),  32'h0);
    check("idle_result", 32'(Result), 32'h33);

    // Lone requester keeps the display past expiry.
    Req = 4'b0100;
    repeat (20) begin
      tick();
      check("lone_grant", 32'(Grant), 32'b0100);
    end
    Req = 4'b0101;
    tick();
    check("lone_rot", 32'(Grant), 32'b0001);

    // Freeze for 6 cycles stretches a 4-cycle dwell to 10.
    Req = 4'b0000;
    tick();
    Req = 4'b0011;
    tick();
    check("frz_first", 32'(Grant), 32'b0010);
    len = 1;
    Freeze = 1'b1;
    repeat (6) begin
      tick();
      if (Grant == 4'b0010) len++;
    end
    Freeze = 1'b0;
    for (int n = 0; n < 20; n++) begin
      tick();
      if (Grant == 4'b0010) len++;
      else break;
    end
    check("frz_len",  32'(len),   32'd10);
    check("frz_next", 32'(Grant), 32'b0001);

    // Reset in the middle of a dwell.
    tick();
    Reset = 1'b1;
    tick();
    check("mid_grant",  32'(Grant),   32'h0);
    check("mid_idx",    32'(Src_Idx), 32'h0);
    check("mid_valid",  32'(Valid),   32'h0);
    check("mid_result", 32'(Result),  32'h0);
    Reset = 1'b0;
    tick();
    check("mid_restart", 32'(Grant), 32'b0001);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mism);
    $finish;
  end

endmodule
